// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard wave scheduler.
package hazard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_WARN,
    ST_ACTIVE,
    ST_COOL
  } state_t;

  localparam int          CELL_COUNT = 9;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  // Folds a raw 4-bit index (0..15) onto the 3x3 board (0..8).
  function automatic logic [3:0] fold9(input logic [3:0] raw);
    return (raw >= 4'd9) ? raw - 4'd9 : raw;
  endfunction

  function automatic logic [3:0] popcount9(input logic [CELL_COUNT-1:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < CELL_COUNT; i++) begin
      c = c + {3'b000, m[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), shifting left every clk.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] lfsr
);
  import hazard_pkg::*;

  // An all-zero seed would lock the register up forever.
  localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= INIT;
    else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Per-wave hazard generator for the 3x3 board: pick cells, warn, go live, cool down.
// Hit and collect are registered one-cycle pulses; dropping enable returns to IDLE.
module hazard_scheduler #(
  parameter int          NUM_CELLS    = 2,
  parameter int          WARN_TICKS   = 2,
  parameter int          ACTIVE_TICKS = 3,
  parameter int          COOL_TICKS   = 1,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       step,
  input  logic       super_mode,  // invulnerability; 'super' is a reserved word
  input  logic [8:0] box,
  output logic [8:0] warning_state,
  output logic [8:0] fire_state,
  output logic [8:0] gold_state,
  output logic       hit,
  output logic       collect,
  output logic [7:0] wave_count
);
  import hazard_pkg::*;

  localparam logic [3:0] CELLS_N     = 4'(NUM_CELLS);
  localparam logic [3:0] WARN_LAST   = 4'(WARN_TICKS - 1);
  localparam logic [3:0] ACTIVE_LAST = 4'(ACTIVE_TICKS - 1);
  localparam logic [3:0] COOL_LAST   = 4'(COOL_TICKS - 1);

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [8:0]  kind, kind_nxt;
  logic [8:0]  warn_nxt, fire_nxt, gold_nxt;
  logic [3:0]  tick, tick_nxt;
  logic        hit_done, hit_done_nxt;
  logic        hit_nxt, collect_nxt;
  logic [7:0]  wave_nxt;
  logic [3:0]  pick_idx;
  logic [8:0]  pick_mask;
  logic        pick_gold;
  logic        unused_lfsr;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign pick_idx    = fold9(lfsr[3:0]);
  assign pick_mask   = 9'b1 << pick_idx;
  assign pick_gold   = (lfsr[5:4] == 2'b11);
  assign unused_lfsr = ^lfsr[15:6];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    warn_nxt     = warning_state;
    kind_nxt     = kind;
    fire_nxt     = fire_state;
    gold_nxt     = gold_state;
    hit_nxt      = 1'b0;
    collect_nxt  = 1'b0;
    hit_done_nxt = hit_done;
    tick_nxt     = tick;
    wave_nxt     = wave_count;

    if (!enable) begin
      state_nxt    = ST_IDLE;
      warn_nxt     = '0;
      kind_nxt     = '0;
      fire_nxt     = '0;
      gold_nxt     = '0;
      hit_done_nxt = 1'b0;
      tick_nxt     = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_PICK;
          tick_nxt  = '0;
        end
        ST_PICK: begin
          if ((warning_state & pick_mask) == '0) begin
            warn_nxt           = warning_state | pick_mask;
            kind_nxt[pick_idx] = pick_gold;
          end
          // Leave on the same edge that fills the mask.
          if (popcount9(warn_nxt) == CELLS_N) begin
            state_nxt = ST_WARN;
            tick_nxt  = '0;
          end
        end
        ST_WARN: begin
          if (step) begin
            if (tick == WARN_LAST) begin
              fire_nxt  = warning_state & ~kind;
              gold_nxt  = warning_state & kind;
              warn_nxt  = '0;
              kind_nxt  = '0;
              tick_nxt  = '0;
              state_nxt = ST_ACTIVE;
            end else begin
              tick_nxt = tick + 4'd1;
            end
          end
        end
        ST_ACTIVE: begin
          if (((fire_state & box) != '0) && !super_mode && !hit_done) begin
            hit_nxt      = 1'b1;
            hit_done_nxt = 1'b1;
          end
          if ((gold_state & box) != '0) begin
            collect_nxt = 1'b1;
            gold_nxt    = gold_state & ~box;
          end
          if (step) begin
            if (tick == ACTIVE_LAST) begin
              fire_nxt  = '0;
              gold_nxt  = '0;
              tick_nxt  = '0;
              state_nxt = ST_COOL;
            end else begin
              tick_nxt = tick + 4'd1;
            end
          end
        end
        ST_COOL: begin
          if (step) begin
            if (tick == COOL_LAST) begin
              wave_nxt     = (wave_count == 8'hFF) ? wave_count : wave_count + 8'd1;
              hit_done_nxt = 1'b0;
              tick_nxt     = '0;
              state_nxt    = ST_PICK;
            end else begin
              tick_nxt = tick + 4'd1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      warning_state <= '0;
      kind          <= '0;
      fire_state    <= '0;
      gold_state    <= '0;
      hit           <= 1'b0;
      collect       <= 1'b0;
      hit_done      <= 1'b0;
      tick          <= '0;
      wave_count    <= '0;
    end else begin
      warning_state <= warn_nxt;
      kind          <= kind_nxt;
      fire_state    <= fire_nxt;
      gold_state    <= gold_nxt;
      hit           <= hit_nxt;
      collect       <= collect_nxt;
      hit_done      <= hit_done_nxt;
      tick          <= tick_nxt;
      wave_count    <= wave_nxt;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler with default parameters.
module tb_hazard_scheduler;

  logic       clk = 1'b0;
  logic       rst, enable, step, super_mode;
  logic [8:0] box;
  logic [8:0] warning_state, fire_state, gold_state;
  logic       hit, collect;
  logic [7:0] wave_count;

  int vectors     = 0;
  int miscompares = 0;
  int hit_cnt     = 0;
  int collect_cnt = 0;
  int exp_waves   = 0;

  always #20 clk = ~clk;

  hazard_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .step          (step),
    .super_mode    (super_mode),
    .box           (box),
    .warning_state (warning_state),
    .fire_state    (fire_state),
    .gold_state    (gold_state),
    .hit           (hit),
    .collect       (collect),
    .wave_count    (wave_count)
  );

  always @(negedge clk) begin
    if (hit)     hit_cnt++;
    if (collect) collect_cnt++;
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic clks(input int n);
    repeat (n) clk1();
  endtask

  task automatic do_step(input int gap);
    step = 1'b1;
    clk1();
    step = 1'b0;
    clks(gap);
  endtask

  task automatic wait_full();
    for (int i = 0; i < 64; i++) begin
      if ($countones(warning_state) == 2) break;
      clk1();
    end
    chk("pick_full", $countones(warning_state), 2);
  endtask

  task automatic to_active(input int gap);
    wait_full();
    do_step(gap);
    do_step(gap);
  endtask

  task automatic finish_wave(input int gap);
    box = '0;
    repeat (3) do_step(gap);
    do_step(gap);
    exp_waves = (exp_waves < 255) ? exp_waves + 1 : 255;
  endtask

  task automatic find_wave(input bit want_gold, output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      to_active(4);
      if (want_gold ? (gold_state != '0) : (fire_state != '0)) begin
        found = 1'b1;
        break;
      end
      finish_wave(4);
    end
  endtask

  initial begin
    logic [8:0] w, gm, g_before, f_before;
    int         h0, c0;
    bit         found;

    rst = 1'b1; enable = 1'b0; step = 1'b0; super_mode = 1'b0; box = '0;
    clks(3);
    chk("rst_warn", warning_state, 0);
    chk("rst_fire", fire_state, 0);
    chk("rst_gold", gold_state, 0);
    chk("rst_hit", hit, 0);
    chk("rst_collect", collect, 0);
    chk("rst_wave", wave_count, 0);
    #5 rst = 1'b0;
    clks(3);
    chk("idle_warn", warning_state, 0);

    enable = 1'b1;
    clk1();
    chk("pick_entry_empty", warning_state, 0);
    clk1();
    chk("first_pick", $countones(warning_state), 1);

    // One full wave with defaults and no player.
    wait_full();
    w  = warning_state;
    h0 = hit_cnt;
    c0 = collect_cnt;
    chk("warn_no_live", fire_state | gold_state, 0);
    do_step(20);
    chk("warn_hold", warning_state, w);
    do_step(20);
    chk("act_mask", fire_state | gold_state, w);
    chk("act_warn_clear", warning_state, 0);
    chk("act_disjoint", fire_state & gold_state, 0);
    do_step(20);
    do_step(20);
    chk("act_hold", fire_state | gold_state, w);
    do_step(20);
    chk("cool_masks", {warning_state, fire_state, gold_state}, 0);
    chk("cool_wave", wave_count, 0);
    do_step(20);
    exp_waves = 1;
    chk("wave1", wave_count, 1);
    chk("wave1_pulses", (hit_cnt - h0) + (collect_cnt - c0), 0);

    // Fire hit: one pulse per wave even with box held.
    find_wave(1'b0, found);
    chk("fire_found", found, 1);
    h0  = hit_cnt;
    box = fire_state;
    clk1();
    chk("hit_pulse", hit, 1);
    clk1();
    chk("hit_once", hit, 0);
    clks(10);
    chk("hit_count", hit_cnt - h0, 1);
    finish_wave(4);
    chk("wave_after_hit", wave_count, exp_waves);

    super_mode = 1'b1;
    find_wave(1'b0, found);
    chk("fire_found_super", found, 1);
    h0  = hit_cnt;
    box = fire_state;
    clks(10);
    chk("super_no_hit", hit_cnt - h0, 0);
    box        = '0;
    super_mode = 1'b0;
    finish_wave(4);

    // Gold collect on the lowest gold cell.
    find_wave(1'b1, found);
    chk("gold_found", found, 1);
    gm       = gold_state & (~gold_state + 9'd1);
    g_before = gold_state;
    f_before = fire_state;
    c0       = collect_cnt;
    h0       = hit_cnt;
    box      = gm;
    clk1();
    chk("collect_pulse", collect, 1);
    chk("gold_cleared", gold_state, g_before & ~gm);
    chk("fire_untouched", fire_state, f_before);
    clk1();
    chk("collect_once", collect, 0);
    clks(5);
    chk("collect_count", collect_cnt - c0, 1);
    chk("gold_no_hit", hit_cnt - h0, 0);
    finish_wave(4);
    chk("wave_after_gold", wave_count, exp_waves);

    // Drop enable in WARN together with a step.
    wait_full();
    do_step(4);
    chk("pre_drop_warn", $countones(warning_state), 2);
    enable = 1'b0;
    step   = 1'b1;
    clk1();
    step = 1'b0;
    chk("dis_warn", warning_state, 0);
    chk("dis_fire", fire_state, 0);
    chk("dis_gold", gold_state, 0);
    chk("dis_wave", wave_count, exp_waves);
    clks(3);
    chk("dis_hold", {warning_state, fire_state, gold_state}, 0);
    enable = 1'b1;
    clk1();
    chk("reidle_empty", warning_state, 0);
    clk1();
    chk("reidle_pick", $countones(warning_state), 1);

    // Asynchronous reset in the middle of ACTIVE.
    to_active(4);
    chk("pre_rst_live", $countones(fire_state | gold_state), 2);
    #5 rst = 1'b1;
    #1;
    chk("arst_warn", warning_state, 0);
    chk("arst_fire", fire_state, 0);
    chk("arst_gold", gold_state, 0);
    chk("arst_hit", hit, 0);
    chk("arst_collect", collect, 0);
    chk("arst_wave", wave_count, 0);
    #5 rst = 1'b0;
    exp_waves = 0;
    clk1();
    chk("post_rst_empty", warning_state, 0);
    clk1();
    chk("post_rst_pick", $countones(warning_state), 1);

    // Saturation of wave_count with no player.
    h0 = hit_cnt;
    c0 = collect_cnt;
    for (int i = 0; i < 260; i++) begin
      to_active(1);
      finish_wave(1);
      if (i == 254) chk("wave_255", wave_count, 255);
    end
    chk("wave_sat", wave_count, 255);
    chk("sat_no_hit", hit_cnt - h0, 0);
    chk("sat_no_collect", collect_cnt - c0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_scheduler.md
Name: hazard_scheduler

Overview:
Generates the per-wave hazard pattern for the 3x3 board. It drives warning_state, fire_state and gold_state for the display controller, and hit/collect pulses for life and score keeping. It sits between the slow-tick/one-pulse logic and the display/score path, running on the 25 MHz pixel-domain clock. Each wave is LFSR-driven: pick cells, warn, go live, cool down, repeat.

Parameters:
NUM_CELLS, 2, distinct cells armed per wave (1..4)
WARN_TICKS, 2, step pulses spent in WARN
ACTIVE_TICKS, 3, step pulses spent in ACTIVE
COOL_TICKS, 1, step pulses spent in COOL
SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001

Ports:
clk  input  1  system clock (25 MHz)
rst  input  1  asynchronous active-high reset
enable  input  1  game running; low forces IDLE
step  input  1  one-cycle pulse per game tick, synchronous to clk
super  input  1  invulnerability; suppresses hit
box  input  9  player-occupied cells, bit i = cell i
warning_state  output  9  cells armed, pre-activation
fire_state  output  9  live fire cells
gold_state  output  9  live, uncollected gold cells
hit  output  1  one-cycle pulse, player touched fire
collect  output  1  one-cycle pulse, player took gold
wave_count  output  8  completed waves, saturating at 255

Behaviour:
- Reset is asynchronous. All outputs are 0, the LFSR is loaded with SEED, and the state is IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It shifts left every clk, with feedback into bit 0, and never reaches 0.
- States: IDLE, PICK, WARN, ACTIVE, COOL.
- IDLE: when enable=1, go to PICK on the next clk.
- PICK, one attempt per clk:
  - idx = lfsr[3:0]; if idx>=9 then idx -= 9.
  - If warning_state[idx]=0, set the bit and record its kind: gold if lfsr[5:4]==2'b11, else fire (kind mask is internal).
  - If the bit is already set, retry on the next clk.
  - When popcount(warning_state)==NUM_CELLS, go to WARN and clear the tick counter.
- WARN: count step pulses. On the WARN_TICKS-th step, go to ACTIVE:
  - fire_state = warn & ~kind; gold_state = warn & kind; warning_state = 0. All of these take effect on the same edge.
- ACTIVE, evaluated every clk:
  - If (fire_state & box)!=0, super=0 and the wave's hit_done flag is 0, then hit=1 for one cycle and hit_done is set. At most one hit per wave.
  - For gold: if (gold_state & box)!=0, clear those bits and pulse collect once. Multiple cells taken in the same cycle still give one pulse.
  - On the ACTIVE_TICKS-th step: fire_state=0, gold_state=0, go to COOL.
  - Hit and collect in the same cycle: both pulse.
- COOL: on the COOL_TICKS-th step, wave_count += 1 (saturating), hit_done is cleared, go to PICK.
- Tick counter width is 4 bits. A step pulse during PICK is ignored.
- enable falling in any state: the next clk clears the three state masks, hit, collect and hit_done, and goes to IDLE. wave_count and the LFSR are preserved.
- enable low with step high: enable wins.
- The LFSR keeps running in every state.
- hit and collect are registered outputs, asserted on the clk after the overlap is seen.
- Latency from enable rising to a full warning mask is at least 1+NUM_CELLS clks.

Decomposition:
- Shared package hazard_pkg holds:
  - state enum (IDLE/PICK/WARN/ACTIVE/COOL)
  - CELL_COUNT=9
  - LFSR tap mask 16'hB400
- One sub-module, lfsr16: seed parameter, free-running, outputs the 16-bit value.
- The mod-9 fold and popcount stay as functions inside the package.

Test Plan:
1. Reset check: assert rst mid-ACTIVE -> all masks, hit and collect are 0 asynchronously, and state is IDLE on release.
2. Defaults, enable=1, step every 20 clks:
   - PICK: warning_state has exactly 2 bits set within 2+retries clks.
   - After the 2nd step: fire_state|gold_state equals the prior warning mask, and warning_state=0.
   - After 3 further steps: all masks are 0.
   - After 1 further step: wave_count=1.
3. Fire hit and super:
   - Drive box equal to the live fire mask, super=0 -> exactly one hit pulse for the wave, even if box is held.
   - Repeat with super=1 -> no hit.
4. Gold collect: force a wave containing gold (scan waves); set box to the gold cell -> one collect pulse, that gold_state bit clears next clk, and fire bits are untouched.
5. Enable low: drop enable during WARN with step=1 in the same cycle -> next clk all masks are 0, state is IDLE, and wave_count is unchanged.
6. Saturation: run 260 waves with box=0 -> wave_count stops at 255, and there are no hit or collect pulses.
